mmcm_rst_ctrl: RTL and testbench
================================

Name: mmcm_rst_ctrl

Overview:
- Initiator side of the MMCM reset/locked interface: drives the active-high reset into mmcm_ip and consumes its asynchronous locked output.
- Sequences MMCM power-up and retries after a lock timeout.
- Qualifies lock stability and releases a system reset (sys_rst_n) to downstream logic.
- Runs on the free-running reference clock that also feeds the MMCM clk_in1 (50 MHz, 20 ns period).

Parameters:
- RST_PULSE_CYC, 8: cycles mmcm_reset is held high per attempt (>=1).
- LOCK_TIMEOUT_CYC, 1000: cycles allowed in WAIT_LOCK before the attempt is declared failed.
- STABLE_CYC, 16: consecutive synchronized locked=1 cycles required before release.
- MAX_RETRY, 3: retries allowed after the first attempt before FAIL.
- SYNC_STAGES, 2: flops in the locked synchronizer (>=2).

Ports:
- clk  in  1  free-running reference clock, same net as MMCM clk_in1
- reset_n  in  1  asynchronous active-low reset
- locked  in  1  MMCM locked, asynchronous to clk
- soft_restart  in  1  single-cycle pulse; restarts the whole sequence
- mmcm_reset  out  1  active-high reset to MMCM
- sys_rst_n  out  1  active-low system reset, deasserted only in RUN
- lock_fail  out  1  sticky; high in FAIL
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries consumed in the current sequence
- lock_loss_cnt  out  8  saturating count of lock losses in RUN

Behaviour:
- Reset values (reset_n=0, asynchronous): state=RST, mmcm_reset=1, sys_rst_n=0, lock_fail=0, retry_cnt=0, lock_loss_cnt=0, all counters 0, synchronizer flops 0.
- locked_s is locked delayed by SYNC_STAGES cycles; the FSM uses only locked_s. All outputs are registered.
- RST: mmcm_reset=1, sys_rst_n=0. Pulse counter runs 0..RST_PULSE_CYC-1. On the last count, go to WAIT_LOCK and clear the wait counter.
- WAIT_LOCK: mmcm_reset=0, sys_rst_n=0. Wait counter increments each cycle.
  - locked_s=1 -> STABLE, stable counter cleared.
  - Wait counter reaches LOCK_TIMEOUT_CYC-1 with locked_s=0: if retry_cnt==MAX_RETRY -> FAIL; else retry_cnt+1 and -> RST.
  - If locked_s=1 and timeout occur in the same cycle, lock wins.
- STABLE: stable counter increments while locked_s=1. The wait counter keeps running; it is not cleared.
  - locked_s=0 -> WAIT_LOCK.
  - Counter reaches STABLE_CYC-1 -> RUN; sys_rst_n goes to 1 on the next edge.
  - Timeout in STABLE is ignored.
- RUN: mmcm_reset=0, sys_rst_n=1.
  - locked_s=0 -> sys_rst_n=0 on the next edge, lock_loss_cnt+1 (saturates at 255), retry_cnt cleared, -> RST.
- FAIL: mmcm_reset=1, sys_rst_n=0, lock_fail=1. Stays until soft_restart or reset_n.
- soft_restart: highest priority in any state. -> RST, clears retry_cnt, lock_fail and the counters. Does not clear lock_loss_cnt.
- reset_n asserted mid-sequence: immediate return to reset values, including mmcm_reset=1.
- Latency, locked rise to sys_rst_n=1: SYNC_STAGES + STABLE_CYC + 1 cycles (19 with defaults).
- Latency, locked fall in RUN to sys_rst_n=0: SYNC_STAGES + 1 cycles (3).

Optional Feature:
- Macro: MMCM_LOCK_LOSS_CNT_EN.
- Defined: lock_loss_cnt counts as described.
- Undefined: counter logic is omitted and lock_loss_cnt is tied to 8'd0; port list is unchanged.

Decomposition:
- Package mmcm_rst_pkg:
  - state enum (RST, WAIT_LOCK, STABLE, RUN, FAIL), 3 bits;
  - LOCK_LOSS_W=8;
  - counter-width helper constants.
- One sub-module: sync_ff, parameterized SYNC_STAGES, async active-low reset. Used for locked.

Test Plan:
- Power-up: reset_n low 100 ns then high; bench raises locked 500 ns later -> mmcm_reset high for exactly 8 cycles; sys_rst_n rises 19 cycles after locked rises; retry_cnt=0.
- Lock never asserts -> 4 mmcm_reset pulses of 8 cycles, 1000-cycle spacing; then lock_fail=1, retry_cnt=3, mmcm_reset held 1.
- Glitch: locked high 10 cycles, low 2, then high -> no release until 16 consecutive synchronized-high cycles; sys_rst_n stays 0 during the glitch.
- Loss in RUN: drop locked -> sys_rst_n=0 within 3 cycles, lock_loss_cnt 0->1, new 8-cycle mmcm_reset pulse; repeated 300 times -> lock_loss_cnt=255. With the macro undefined -> stays 0.
- Recovery from FAIL: soft_restart pulse in FAIL -> lock_fail=0, retry_cnt=0, RST entered next cycle.
- Priority: soft_restart in the same cycle as a timeout, and reset_n asserted during STABLE -> soft_restart wins; reset_n forces mmcm_reset=1, sys_rst_n=0 asynchronously.

Source files
------------

// File: rtl/mmcm_rst_pkg.sv
// Shared types and constants for the MMCM reset/lock controller.
// Holds the controller state encoding, the lock-loss counter width and a
// helper that sizes a counter able to hold the values 0..n-1.
package mmcm_rst_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int unsigned LOCK_LOSS_W   = 8;
  localparam int unsigned LOCK_LOSS_MAX = (32'd1 << LOCK_LOSS_W) - 32'd1;

  // Bits needed for a counter running 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'(unsigned'($clog2(n)));
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d_i    asynchronous input
//   q_o    input delayed by SYNC_STAGES clk cycles
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain; stage 0 is the only flop that may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mmcm_rst_ctrl.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a qualified lock,
// retries on timeout and releases the downstream system reset.
// Ports:
//   clk            free-running reference clock (also MMCM clk_in1)
//   reset_n        asynchronous active-low reset
//   locked         MMCM locked, asynchronous to clk
//   soft_restart   single-cycle pulse restarting the whole sequence
//   mmcm_reset     active-high reset into the MMCM
//   sys_rst_n      active-low system reset, released only while running
//   lock_fail      high once all retries are exhausted
//   retry_cnt      retries consumed in the current sequence
//   lock_loss_cnt  saturating count of lock losses while running
// Build option: define MMCM_LOCK_LOSS_CNT_EN to include the lock-loss
// counter; otherwise lock_loss_cnt is tied to zero.
module mmcm_rst_ctrl
  import mmcm_rst_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 8,
  parameter int unsigned LOCK_TIMEOUT_CYC = 1000,
  parameter int unsigned STABLE_CYC       = 16,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned SYNC_STAGES      = 2,
  localparam int unsigned RETRY_W         = cnt_w(MAX_RETRY + 32'd1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic                   soft_restart,
  output logic                   mmcm_reset,
  output logic                   sys_rst_n,
  output logic                   lock_fail,
  output logic [RETRY_W-1:0]     retry_cnt,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam int unsigned PULSE_W  = cnt_w(RST_PULSE_CYC);
  localparam int unsigned WAIT_W   = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int unsigned STABLE_W = cnt_w(STABLE_CYC);

  state_e                state_q, state_d;
  logic [PULSE_W-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [STABLE_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  mmcm_reset_q, mmcm_reset_d;
  logic                  sys_rst_n_q, sys_rst_n_d;
  logic                  lock_fail_q, lock_fail_d;
  logic                  locked_s;
  logic                  wait_timeout_c;
  logic [WAIT_W-1:0]     wait_cnt_inc_c;

  // Bring the MMCM locked level into the clk domain.
  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (locked),
    .q_o  (locked_s)
  );

  // Wait counter saturates at the timeout value: it keeps running through
  // STABLE, so a return to WAIT_LOCK after the deadline times out at once.
  assign wait_timeout_c = (wait_cnt_q >= WAIT_W'(LOCK_TIMEOUT_CYC - 32'd1));
  assign wait_cnt_inc_c = wait_timeout_c ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet change on the same edge as the state.
  always_comb begin : fsm_comb
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stable_cnt_d = stable_cnt_q;
    retry_d      = retry_q;

    if (soft_restart) begin
      state_d      = ST_RST;
      pulse_cnt_d  = '0;
      wait_cnt_d   = '0;
      stable_cnt_d = '0;
      retry_d      = '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (pulse_cnt_q == PULSE_W'(RST_PULSE_CYC - 32'd1)) begin
            state_d     = ST_WAIT_LOCK;
            pulse_cnt_d = '0;
            wait_cnt_d  = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          wait_cnt_d = wait_cnt_inc_c;
          // A lock seen in the timeout cycle still wins.
          if (locked_s) begin
            state_d      = ST_STABLE;
            stable_cnt_d = '0;
          end else if (wait_timeout_c) begin
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
              state_d = ST_FAIL;
            end else begin
              state_d     = ST_RST;
              retry_d     = retry_q + RETRY_W'(1);
              pulse_cnt_d = '0;
            end
          end
        end
        ST_STABLE: begin
          wait_cnt_d = wait_cnt_inc_c;
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stable_cnt_q == STABLE_W'(STABLE_CYC - 32'd1)) begin
            state_d = ST_RUN;
          end else begin
            stable_cnt_d = stable_cnt_q + STABLE_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d     = ST_RST;
            pulse_cnt_d = '0;
            retry_d     = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RST;
        end
      endcase
    end

    mmcm_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    sys_rst_n_d  = (state_d == ST_RUN);
    lock_fail_d  = (state_d == ST_FAIL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST;
      pulse_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      stable_cnt_q <= '0;
      retry_q      <= '0;
      mmcm_reset_q <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      lock_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      retry_q      <= retry_d;
      mmcm_reset_q <= mmcm_reset_d;
      sys_rst_n_q  <= sys_rst_n_d;
      lock_fail_q  <= lock_fail_d;
    end
  end

`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [LOCK_LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                   loss_evt_c;

  // A loss is the RUN -> RST transition; soft_restart pre-empts it.
  always_comb begin : loss_comb
    loss_evt_c = !soft_restart && (state_q == ST_RUN) && !locked_s;
    loss_cnt_d = loss_cnt_q;
    if (loss_evt_c && (loss_cnt_q != LOCK_LOSS_W'(LOCK_LOSS_MAX))) begin
      loss_cnt_d = loss_cnt_q + LOCK_LOSS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign mmcm_reset = mmcm_reset_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign lock_fail  = lock_fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_mmcm_rst_ctrl.sv
// Self-checking bench for mmcm_rst_ctrl: directed scenarios plus random
// locked/soft_restart traffic, all compared every cycle against a timer and
// run-length reference model.
`timescale 1ns/1ps
module tb_mmcm_rst_ctrl;

  localparam int P_PULSE  = 8;
  localparam int P_TO     = 1000;
  localparam int P_STABLE = 16;
  localparam int P_RETRY  = 3;
  localparam int P_SYNC   = 2;
`ifdef MMCM_LOCK_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       soft_restart;
  logic       mmcm_reset;
  logic       sys_rst_n;
  logic       lock_fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mmcm_rst_ctrl u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .soft_restart (soft_restart),
    .mmcm_reset   (mmcm_reset),
    .sys_rst_n    (sys_rst_n),
    .lock_fail    (lock_fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: time since the attempt began, run length of
  // synchronized-high samples after the pulse, and release/fail flags.
  int m_att, m_hi, m_retry, m_loss;
  bit m_rel, m_fail, m_s1, m_s2;

  task model_reset();
    m_att = 0; m_hi = 0; m_retry = 0; m_loss = 0;
    m_rel = 0; m_fail = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task model_step(input bit lk, input bit sr);
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (sr) begin
      m_att = 0; m_hi = 0; m_rel = 0; m_fail = 0; m_retry = 0;
    end else if (m_fail) begin
      m_fail = 1;
    end else if (m_rel) begin
      if (!ls) begin
        m_rel = 0; m_att = 0; m_hi = 0; m_retry = 0;
        if (LOSS_EN != 0 && m_loss < 255) m_loss++;
      end
    end else if (m_att < P_PULSE) begin
      m_att++;
    end else if (ls) begin
      m_hi++;
      m_att++;
      if (m_hi >= P_STABLE + 1) m_rel = 1;
    end else if (m_hi == 0 && (m_att - P_PULSE) >= P_TO - 1) begin
      if (m_retry == P_RETRY) m_fail = 1;
      else begin
        m_retry++;
        m_att = 0;
      end
    end else begin
      m_hi = 0;
      m_att++;
    end
  endtask

  // Lock-step model comparison, 1 ns after every rising edge.
  initial begin : model_chk
    bit exp_mr;
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step(locked, soft_restart);
      #1;
      exp_mr = m_fail || (!m_rel && m_att < P_PULSE);
      check_eq("mdl_mmcm_reset", 32'(mmcm_reset), 32'(exp_mr));
      check_eq("mdl_sys_rst_n", 32'(sys_rst_n), 32'(m_rel));
      check_eq("mdl_lock_fail", 32'(lock_fail), 32'(m_fail));
      check_eq("mdl_retry_cnt", 32'(retry_cnt), m_retry);
      check_eq("mdl_lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
    end
  end

  // Edges until sys_rst_n reads val (sampled 1 ns after each edge).
  task automatic wait_sys(input logic val, input int budget, input string tag, output int n);
    bit done;
    done = 0;
    n = -1;
    for (int k = 1; k <= budget && !done; k++) begin
      @(posedge clk);
      #1;
      if (sys_rst_n === val) begin
        n = k;
        done = 1;
      end
    end
    if (!done) check_eq({tag, "_timeout"}, 32'(sys_rst_n), 32'(val));
  endtask

  // Samples (including the current one) for which mmcm_reset stays high.
  task automatic measure_high(output int n);
    n = 0;
    while (mmcm_reset === 1'b1 && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sr();
    @(posedge clk);
    #2 soft_restart = 1'b1;
    @(posedge clk);
    #2 soft_restart = 1'b0;
  endtask

  task automatic drive_cycles(input logic val, input int n);
    locked = val;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    int n;
    int t_rel;
    int runs[$];
    int run_len;
    bit cur;
    bit any_hi;
    bit reached;

    reset_n = 1'b0;
    locked = 1'b0;
    soft_restart = 1'b0;

    // Reset values.
    #50;
    check_eq("rst_mmcm_reset", 32'(mmcm_reset), 1);
    check_eq("rst_sys_rst_n", 32'(sys_rst_n), 0);
    check_eq("rst_lock_fail", 32'(lock_fail), 0);
    check_eq("rst_retry_cnt", 32'(retry_cnt), 0);
    check_eq("rst_lock_loss_cnt", 32'(lock_loss_cnt), 0);

    // Power-up: 8-cycle pulse, then lock 500 ns after release.
    #50;
    reset_n = 1'b1;
    t_rel = int'($time);
    measure_high(n);
    check_eq("pwr_pulse_len", n, P_PULSE);
    while (int'($time) < t_rel + 500) #1;
    locked = 1'b1;
    wait_sys(1'b1, 100, "pwr_release", n);
    check_eq("pwr_release_latency", n, P_SYNC + P_STABLE + 1);
    check_eq("pwr_retry_cnt", 32'(retry_cnt), 0);

    // Lock loss in RUN.
    locked = 1'b0;
    wait_sys(1'b0, 20, "loss_drop", n);
    check_eq("loss_drop_latency", n, P_SYNC + 1);
    check_eq("loss_cnt_after_one", 32'(lock_loss_cnt), LOSS_EN);
    check_eq("loss_retry_cnt", 32'(retry_cnt), 0);
    measure_high(n);
    check_eq("loss_pulse_len", n, P_PULSE);

    // Glitch: 10 high, 2 low, then high again.
    any_hi = 0;
    locked = 1'b1;
    repeat (10) begin @(posedge clk); #1; any_hi |= sys_rst_n; end
    locked = 1'b0;
    repeat (2) begin @(posedge clk); #1; any_hi |= sys_rst_n; end
    locked = 1'b1;
    wait_sys(1'b1, 60, "glitch_release", n);
    check_eq("glitch_no_early_release", 32'(any_hi), 0);
    check_eq("glitch_release_latency", n, P_SYNC + P_STABLE + 1);

    // Lock never asserts: four pulses spaced by the timeout, then FAIL.
    locked = 1'b0;
    pulse_sr();
    cur = 1'b1;
    run_len = 0;
    reached = 0;
    for (int k = 0; k < 6000 && !reached; k++) begin
      if (lock_fail === 1'b1) begin
        reached = 1;
      end else begin
        if (mmcm_reset === cur) run_len++;
        else begin
          runs.push_back(run_len);
          cur = mmcm_reset;
          run_len = 1;
        end
        @(posedge clk);
        #1;
      end
    end
    runs.push_back(run_len);
    check_eq("never_reached_fail", 32'(lock_fail), 1);
    check_eq("never_run_count", runs.size(), 2 * (P_RETRY + 1));
    foreach (runs[i]) check_eq($sformatf("never_run_%0d", i), runs[i], (i % 2 == 0) ? P_PULSE : P_TO);
    check_eq("never_retry_cnt", 32'(retry_cnt), P_RETRY);
    check_eq("never_mmcm_reset", 32'(mmcm_reset), 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("fail_sticky", 32'(lock_fail), 1);
    check_eq("fail_mmcm_held", 32'(mmcm_reset), 1);

    // Recovery from FAIL.
    pulse_sr();
    check_eq("recover_lock_fail", 32'(lock_fail), 0);
    check_eq("recover_retry_cnt", 32'(retry_cnt), 0);
    check_eq("recover_mmcm_reset", 32'(mmcm_reset), 1);

    // soft_restart in the timeout cycle wins over the retry.
    repeat (P_PULSE + P_TO - 1) @(posedge clk);
    #2 soft_restart = 1'b1;
    @(posedge clk);
    #1;
    check_eq("prio_retry_cnt", 32'(retry_cnt), 0);
    check_eq("prio_mmcm_reset", 32'(mmcm_reset), 1);
    check_eq("prio_lock_fail", 32'(lock_fail), 0);
    #1 soft_restart = 1'b0;

    // reset_n asserted during STABLE acts immediately.
    locked = 1'b1;
    repeat (12) @(posedge clk);
    #4 reset_n = 1'b0;
    #1;
    check_eq("arst_stable_mmcm_reset", 32'(mmcm_reset), 1);
    check_eq("arst_stable_sys_rst_n", 32'(sys_rst_n), 0);
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;
    wait_sys(1'b1, 100, "arst_release", n);
    check_eq("arst_release_latency", n, P_PULSE + 1 + P_STABLE);

    // reset_n asserted in RUN drops sys_rst_n without a clock edge.
    #4 reset_n = 1'b0;
    #1;
    check_eq("arst_run_sys_rst_n", 32'(sys_rst_n), 0);
    check_eq("arst_run_mmcm_reset", 32'(mmcm_reset), 1);
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;

    // Random lock traffic with occasional soft restarts.
    for (int i = 0; i < 60; i++) begin
      drive_cycles(1'b1, int'($urandom_range(1, 40)));
      drive_cycles(1'b0, int'($urandom_range(1, 25)));
      if ($urandom_range(0, 7) == 0) pulse_sr();
    end

    // Repeated losses saturate the counter.
    pulse_sr();
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      wait_sys(1'b1, 100, "sat_release", n);
      locked = 1'b0;
      wait_sys(1'b0, 10, "sat_drop", n);
    end
    #1;
    check_eq("loss_cnt_saturated", 32'(lock_loss_cnt), (LOSS_EN != 0) ? 255 : 0);

    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
